// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO burst traffic generator/checker.
// FSM state encoding, default data width and FIFO depth.
package fifo_test_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int FIFO_DEPTH = 256;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pattern_checker.sv
// Compares read-back bytes against an incrementing pattern.
// Keeps a sticky error flag and a saturating mismatch count.
module pattern_checker
   import fifo_test_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 clr,
   input  logic                 vld,
   input  logic [DATA_W-1:0]    data,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [DATA_W-1:0] exp_byte;

   // expected-byte tracking, mismatch flag and saturating count
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         exp_byte <= '0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else if (clr) begin
         exp_byte <= '0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else if (vld) begin
         exp_byte <= exp_byte + 1'b1;
         if (data != exp_byte) begin
            err <= 1'b1;
            if (err_cnt != {ERR_CNT_W{1'b1}})
               err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Fill/drain traffic generator for a 256-deep FIFO.
// Writes an incrementing pattern, reads it back and checks it.
module fifo_burst_ctrl
   import fifo_test_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int NUM_ROUNDS = 4,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 start,
   input  logic                 stop,
   output logic [DATA_W-1:0]    wr_data,
   output logic                 wr_en,
   output logic                 rd_en,
   input  logic [DATA_W-1:0]    rd_data,
   input  logic                 full,
   input  logic                 empty,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [7:0] LAST_ROUND = 8'(NUM_ROUNDS - 1);

   state_t     state;
   logic [7:0] round;
   logic       rd_vld;
   logic       clr;

   // Strobes are combinational so a flag or stop blocks
   // the access in the very cycle it is seen.
   assign wr_en = (state == S_FILL) && !full && !stop;
   assign rd_en = (state == S_DRAIN) && !empty && !stop;
   assign busy  = (state != S_IDLE);
   assign done  = (state == S_DONE);
   assign clr   = (state == S_IDLE) && start;

   // FSM, write-pattern counter and read-valid pipeline
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state   <= S_IDLE;
         wr_data <= '0;
         round   <= '0;
         rd_vld  <= 1'b0;
      end else begin
         rd_vld <= rd_en;
         if (wr_en)
            wr_data <= wr_data + 1'b1;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_FILL;
                  wr_data <= '0;
                  round   <= '0;
               end
            end
            S_FILL: begin
               if (stop)
                  state <= S_IDLE;
               else if (full)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (stop) begin
                  state <= S_IDLE;
               end else if (empty && !rd_vld) begin
                  if (round == LAST_ROUND) begin
                     state <= S_DONE;
                  end else begin
                     round <= round + 1'b1;
                     state <= S_FILL;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   pattern_checker #(
      .DATA_W    (DATA_W),
      .ERR_CNT_W (ERR_CNT_W)
   ) u_chk (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (clr),
      .vld       (rd_vld),
      .data      (rd_data),
      .err       (err),
      .err_cnt   (err_cnt)
   );

endmodule

// File: doc/fifo_burst_ctrl.md
# fifo_burst_ctrl

Traffic generator and checker for the 8x256 synchronous FIFO on the single `sys_clk` domain. It fills the FIFO with an incrementing byte pattern until `full`, then drains it until `empty`, and checks every read byte against the expected sequence. This repeats for a configurable number of rounds. It connects directly to the FIFO wrapper's write and read ports and reports pass/fail status to the top level or the bench.

## Interface
- `DATA_W`, 8: FIFO data width.
- `NUM_ROUNDS`, 4: fill/drain rounds per `start`, range 1..255.
- `ERR_CNT_W`, 8: width of the saturating mismatch counter.

- `sys_clk`  in  1  single clock; all logic is rising-edge.
- `sys_rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `stop`  in  1  abort request; honoured in any non-IDLE state.
- `wr_data`  out  DATA_W  pattern byte to FIFO `wr_data`.
- `wr_en`  out  1  FIFO write strobe.
- `rd_en`  out  1  FIFO read strobe.
- `rd_data`  in  DATA_W  FIFO `rd_data`, standard (non-FWFT) mode: valid 1 cycle after `rd_en`.
- `full`  in  1  FIFO full flag.
- `empty`  in  1  FIFO empty flag.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last round completes.
- `err`  out  1  sticky mismatch flag; cleared on `start`.
- `err_cnt`  out  ERR_CNT_W  saturating count of mismatched bytes; cleared on `start`.

## Operation
- **States:** IDLE, FILL, DRAIN, DONE.
- **Reset values:** state IDLE, `wr_data` 0, `wr_en` 0, `rd_en` 0, `busy` 0, `done` 0, `err` 0, `err_cnt` 0. Internal counters (`exp`, `round`, `rd_vld`) also reset to 0.
- **IDLE -> FILL** on `start`. This transition clears `wr_data`, `exp`, `round`, `err` and `err_cnt`.
- **FILL:**
  - `wr_en = (state==FILL) & !full & !stop`. This is combinational so that no write is issued while `full` is high.
  - Each cycle with `wr_en` high, `wr_data` increments mod 2^DATA_W.
  - FILL -> DRAIN on the first cycle `full` is seen high.
- **DRAIN:**
  - `rd_en = (state==DRAIN) & !empty & !stop`, also combinational.
  - `rd_vld` is a register loaded from `rd_en`.
  - When `rd_vld` is high, compare `rd_data` against `exp`, then increment `exp` mod 2^DATA_W.
  - On mismatch, set `err` and increment `err_cnt`, saturating at all-ones.
- **DRAIN exit** when `empty & !rd_vld`, so the final byte is checked before leaving.
  - If `round == NUM_ROUNDS-1`, go to DONE.
  - Otherwise increment `round` and go to FILL.
- **Pattern across rounds:** the pattern continues and is not restarted. With a 256-deep FIFO, every round writes and expects 0x00..0xFF.
- **DONE:** pulse `done` for one cycle, then go to IDLE.
- **stop:** from FILL or DRAIN, go to IDLE. `wr_en`/`rd_en` are low in the same cycle; the FIFO is not flushed. `err`/`err_cnt` hold their values and `done` does not pulse.
- **start while busy:** ignored.
- **start and stop together in IDLE:** `start` wins.
- **Reset mid-operation:** all registers return to reset values on the next edge; outstanding `rd_vld` data is discarded.

## Timing
- **`start` at edge N:** FILL from N+1, with the first `wr_en` (data 0x00) in cycle N+1.
- **Full fill:** 256 back-to-back writes occupy cycles N+1..N+256. `full` rises after the 256th write; DRAIN is entered the following edge.
- **Reads:** back-to-back `rd_en` for 256 cycles. Each byte is compared one cycle after its `rd_en`.
- **Throughput:** one write per cycle in FILL and one read per cycle in DRAIN; no bubbles except at state changes (at most 2 cycles per transition).
- **Round latency:** about 515 cycles per round for depth 256.
- **`done`:** asserted one cycle after DRAIN exits on the final round.

## Structure
- **Shared package `fifo_test_pkg`:**
  - state encoding (IDLE=0, FILL=1, DRAIN=2, DONE=3)
  - `DATA_W` default
  - FIFO depth constant 256
- **Sub-module `pattern_checker`:** holds the `exp` register, the compare logic and the saturating `err_cnt`. Inputs: `sys_clk`, `sys_rst_n`, `clr`, `vld`, `data`.
- **Top module:** the FSM and the write-pattern counter.

## Test plan
All scenarios use a behavioural 256-deep standard-mode FIFO model.
- **Single round:** `NUM_ROUNDS`=1, pulse `start` -> 256 writes 0x00..0xFF, 256 reads; `done` pulses once, `err`=0, `err_cnt`=0, `busy` falls on the cycle after `done`.
- **Corrupted byte:** default rounds; the model corrupts byte 0x37 in round 2 -> `err`=1 from the cycle after that read, `err_cnt`=1 at `done`; `done` still pulses after 4 rounds.
- **Saturation:** the model inverts every byte, `ERR_CNT_W`=8, 4 rounds -> `err_cnt` saturates at 0xFF and never wraps.
- **Stop mid-fill:** assert `stop` in FILL after 100 writes -> `wr_en` low the same cycle, `busy`=0 next cycle, no `done`. FIFO holds 100 words.
- **Reset mid-drain:** drop `sys_rst_n` for 1 cycle at read 50 -> all outputs return to reset values on the next edge; a new `start` after flushing the model completes cleanly.
- **Start during busy:** pulse `start` in DRAIN -> ignored, with no change to `round`, `err` or `exp`.
